// File: rtl/mac_sched_pkg.sv
// Shared types and width helpers for the MAC row scheduler and its FPMac datapath.
package mac_sched_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUTPUT} sched_state_t;

  localparam int FRAC_BITS = 8;
  localparam logic [15:0] FIX8_8_ALL_ONES = 16'hFFFF;

  function automatic int ROW_W(input int num_rows);
    return (num_rows > 1) ? $clog2(num_rows) : 1;
  endfunction

  function automatic int CHUNK_W(input int num_chunks);
    return $clog2(num_chunks);
  endfunction

  // Wide enough that NUM_CHUNKS saturated partials can never wrap.
  function automatic int ACC_W(input int data_width, input int num_chunks);
    return data_width + $clog2(num_chunks);
  endfunction

endpackage

// File: rtl/FPMac.sv
// Combinational unsigned Fix8_8 dot product: products are summed at full precision,
// rescaled by truncation back to Fix8_8 and clamped to all-ones on overflow.
module FPMac
  import mac_sched_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int DATA_LENGTH       = 4
) (
  input  logic [INPUT_DATA_WIDTH-1:0]  a [DATA_LENGTH],
  input  logic [INPUT_DATA_WIDTH-1:0]  b [DATA_LENGTH],
  output logic [OUTPUT_DATA_WIDTH-1:0] out
);

  localparam int SUM_W = 2 * INPUT_DATA_WIDTH + $clog2(DATA_LENGTH) + 1;
  localparam logic [SUM_W-1:0] OUT_MAX = SUM_W'({OUTPUT_DATA_WIDTH{1'b1}});

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] scaled;

  always_comb begin
    sum = '0;
    for (int k = 0; k < DATA_LENGTH; k++) begin
      sum = sum + SUM_W'(a[k]) * SUM_W'(b[k]);
    end
    scaled = sum >> FRAC_BITS;
    out = (scaled > OUT_MAX) ? {OUTPUT_DATA_WIDTH{1'b1}} : scaled[OUTPUT_DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/mac_row_scheduler.sv
// Walks one FPMac over NUM_ROWS x NUM_CHUNKS operand chunks, sums the per-chunk
// partials with saturation and hands one Fix8_8 result per row downstream.
module mac_row_scheduler
  import mac_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DATA_LENGTH = 4,
  parameter int NUM_CHUNKS  = 4,
  parameter int NUM_ROWS    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              rd_en,
  output logic [ROW_W(NUM_ROWS)-1:0]        rd_row,
  output logic [CHUNK_W(NUM_CHUNKS)-1:0]    rd_chunk,
  input  logic [DATA_LENGTH*DATA_WIDTH-1:0] a_chunk,
  input  logic [DATA_LENGTH*DATA_WIDTH-1:0] b_chunk,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [ROW_W(NUM_ROWS)-1:0]        out_row,
  output logic                              done
);

  localparam int RW = ROW_W(NUM_ROWS);
  localparam int CW = CHUNK_W(NUM_CHUNKS);
  localparam int AW = ACC_W(DATA_WIDTH, NUM_CHUNKS);
  localparam logic [RW-1:0] LAST_ROW   = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);
  localparam logic [AW-1:0] OUT_MAX    = AW'({DATA_WIDTH{1'b1}});
  localparam logic [DATA_WIDTH-1:0] SAT_ONES =
    (DATA_WIDTH == 16) ? DATA_WIDTH'(FIX8_8_ALL_ONES) : {DATA_WIDTH{1'b1}};

  sched_state_t          state;
  logic [RW-1:0]         row;
  logic [CW-1:0]         chunk;
  logic [AW-1:0]         acc;
  logic [AW-1:0]         acc_next;
  logic                  rd_en_d;
  logic                  first_d;
  logic [DATA_WIDTH-1:0] mac_out;
  logic [DATA_WIDTH-1:0] a_elem [DATA_LENGTH];
  logic [DATA_WIDTH-1:0] b_elem [DATA_LENGTH];

  for (genvar k = 0; k < DATA_LENGTH; k++) begin : g_unpack
    assign a_elem[k] = a_chunk[k*DATA_WIDTH +: DATA_WIDTH];
    assign b_elem[k] = b_chunk[k*DATA_WIDTH +: DATA_WIDTH];
  end

  FPMac #(
    .INPUT_DATA_WIDTH (DATA_WIDTH),
    .OUTPUT_DATA_WIDTH(DATA_WIDTH),
    .DATA_LENGTH      (DATA_LENGTH)
  ) u_mac (
    .a  (a_elem),
    .b  (b_elem),
    .out(mac_out)
  );

  always_comb begin
    acc_next = first_d ? AW'(mac_out) : acc + AW'(mac_out);
  end

  assign busy      = (state != IDLE);
  assign rd_en     = (state == FETCH);
  assign out_valid = (state == OUTPUT);
  assign rd_row    = row;
  assign rd_chunk  = chunk;

  // Read data lags rd_en by one cycle, so the delayed flags mark which cycles carry
  // a real partial; DRAIN is the cycle holding the row's last chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row      <= '0;
      chunk    <= '0;
      acc      <= '0;
      rd_en_d  <= 1'b0;
      first_d  <= 1'b0;
      out_data <= '0;
      out_row  <= '0;
      done     <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_en_d <= (state == FETCH);
      first_d <= (state == FETCH) && (chunk == '0);
      if (rd_en_d) acc <= acc_next;
      case (state)
        IDLE: begin
          if (start) begin
            row   <= '0;
            chunk <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (chunk == LAST_CHUNK) begin
            chunk <= '0;
            state <= DRAIN;
          end else begin
            chunk <= chunk + 1'b1;
          end
        end
        DRAIN: begin
          out_data <= (acc_next > OUT_MAX) ? SAT_ONES : acc_next[DATA_WIDTH-1:0];
          out_row  <= row;
          state    <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            if (row == LAST_ROW) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              row   <= row + 1'b1;
              chunk <= '0;
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
